// File: rtl/bounce_game_ctrl.sv
// Game-state and score keeper for the bounce-the-ball game: tracks the BCD score,
// remaining lives and the NEWGAME/PLAY/NEWBALL/OVER sequence, with registered outputs.
module bounce_game_ctrl #(
    parameter int INIT_BALLS   = 3,
    parameter int TIMER_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_clr,
    input  logic       hit,
    input  logic       miss,
    input  logic       refr_tick,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [1:0] ball,
    output logic       play,
    output logic       over
);

    localparam logic [1:0] BALLS_INIT = 2'(INIT_BALLS);
    localparam logic [6:0] TIMER_INIT = 7'(TIMER_FRAMES);

    typedef enum logic [1:0] {
        NEWGAME = 2'd0,
        PLAY    = 2'd1,
        NEWBALL = 2'd2,
        OVER    = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] dig0_q, dig0_d;
    logic [3:0] dig1_q, dig1_d;
    logic [1:0] ball_q, ball_d;
    logic [6:0] timer_q, timer_d;
    logic       play_q, play_d;
    logic       over_q, over_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= NEWGAME;
            dig0_q  <= 4'd0;
            dig1_q  <= 4'd0;
            ball_q  <= BALLS_INIT;
            timer_q <= 7'd0;
            play_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dig0_q  <= dig0_d;
            dig1_q  <= dig1_d;
            ball_q  <= ball_d;
            timer_q <= timer_d;
            play_q  <= play_d;
            over_q  <= over_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dig0_d  = dig0_q;
        dig1_d  = dig1_q;
        ball_d  = ball_q;
        timer_d = timer_q;

        // btn_clr overrides everything, including a miss or start in the same cycle
        if (btn_clr) begin
            state_d = NEWGAME;
            dig0_d  = 4'd0;
            dig1_d  = 4'd0;
            ball_d  = BALLS_INIT;
            timer_d = 7'd0;
        end else begin
            case (state_q)
                NEWGAME: begin
                    dig0_d  = 4'd0;
                    dig1_d  = 4'd0;
                    ball_d  = BALLS_INIT;
                    timer_d = 7'd0;
                    if (btn_start) state_d = PLAY;
                end
                PLAY: begin
                    if (miss) begin
                        timer_d = TIMER_INIT;
                        if (ball_q > 2'd1) begin
                            ball_d  = ball_q - 2'd1;
                            state_d = NEWBALL;
                        end else begin
                            ball_d  = 2'd0;
                            state_d = OVER;
                        end
                    end else if (hit) begin
                        if (dig0_q == 4'd9) begin
                            dig0_d = 4'd0;
                            dig1_d = (dig1_q == 4'd9) ? 4'd0 : dig1_q + 4'd1;
                        end else begin
                            dig0_d = dig0_q + 4'd1;
                        end
                    end
                end
                NEWBALL: begin
                    if (timer_q == 7'd0) begin
                        if (btn_start) state_d = PLAY;
                    end else if (refr_tick) begin
                        timer_d = timer_q - 7'd1;
                    end
                end
                OVER: begin
                    // Score stays visible until the timer runs out, then a fresh game is loaded
                    if (timer_q == 7'd0) begin
                        state_d = NEWGAME;
                        dig0_d  = 4'd0;
                        dig1_d  = 4'd0;
                        ball_d  = BALLS_INIT;
                    end else if (refr_tick) begin
                        timer_d = timer_q - 7'd1;
                    end
                end
                default: state_d = NEWGAME;
            endcase
        end

        play_d = (state_d == PLAY);
        over_d = (state_d == OVER);
    end

    assign dig0 = dig0_q;
    assign dig1 = dig1_q;
    assign ball = ball_q;
    assign play = play_q;
    assign over = over_q;

endmodule

// File: tb/tb_bounce_game_ctrl.sv
// Self-checking bench for bounce_game_ctrl: a vector table for basic behaviour plus
// hand-written multi-cycle sequences, all compared through an expected-output queue.
module tb_bounce_game_ctrl;

    typedef struct packed {
        logic [3:0] dig1;
        logic [3:0] dig0;
        logic [1:0] ball;
        logic       play;
        logic       over;
    } out_t;

    typedef struct packed {
        logic start;
        logic clr;
        logic hit;
        logic miss;
        logic tick;
    } in_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    localparam in_t IDLE  = 5'b00000;
    localparam in_t START = 5'b10000;
    localparam in_t CLR   = 5'b01000;
    localparam in_t HIT   = 5'b00100;
    localparam in_t MISS  = 5'b00010;
    localparam in_t TICK  = 5'b00001;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_start, btn_clr, hit, miss, refr_tick;
    logic [3:0] dig0, dig1;
    logic [1:0] ball;
    logic       play, over;

    int   n_vec  = 0;
    int   n_fail = 0;
    out_t exp_q[$];
    vec_t vecs[13];

    bounce_game_ctrl #(.INIT_BALLS(3), .TIMER_FRAMES(120)) dut (
        .clk(clk), .reset(reset), .btn_start(btn_start), .btn_clr(btn_clr),
        .hit(hit), .miss(miss), .refr_tick(refr_tick),
        .dig0(dig0), .dig1(dig1), .ball(ball), .play(play), .over(over)
    );

    always #5 clk = ~clk;

    function automatic out_t o(int d1, int d0, int b, int p, int ov);
        out_t r;
        r.dig1 = 4'(d1);
        r.dig0 = 4'(d0);
        r.ball = 2'(b);
        r.play = 1'(p);
        r.over = 1'(ov);
        return r;
    endfunction

    function automatic vec_t mk(in_t i, out_t e);
        vec_t v;
        v.in  = i;
        v.exp = e;
        return v;
    endfunction

    task automatic compareNow(input out_t e, input string name);
        out_t got;
        got = {dig1, dig0, ball, play, over};
        n_vec++;
        if (got !== e) begin
            n_fail++;
            $display("[TB] FAIL %s: got dig1=%0d dig0=%0d ball=%0d play=%0b over=%0b, expected dig1=%0d dig0=%0d ball=%0d play=%0b over=%0b",
                     name, got.dig1, got.dig0, got.ball, got.play, got.over,
                     e.dig1, e.dig0, e.ball, e.play, e.over);
        end
    endtask

    task automatic checkOutput(input string name);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL %s: scoreboard empty, no expected value queued", name);
        end else begin
            compareNow(exp_q.pop_front(), name);
        end
    endtask

    // Drive inputs just after an edge, queue the expectation, check 1 time unit after the next edge
    task automatic applyStimulus(input in_t i, input out_t e, input string name);
        btn_start = i.start;
        btn_clr   = i.clr;
        hit       = i.hit;
        miss      = i.miss;
        refr_tick = i.tick;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = mk(START,       o(0, 0, 3, 1, 0));
        vecs[1]  = mk(IDLE,        o(0, 0, 3, 1, 0));
        vecs[2]  = mk(HIT,         o(0, 1, 3, 1, 0));
        vecs[3]  = mk(HIT,         o(0, 2, 3, 1, 0));
        vecs[4]  = mk(HIT | MISS,  o(0, 2, 2, 0, 0));
        vecs[5]  = mk(START,       o(0, 2, 2, 0, 0));
        vecs[6]  = mk(HIT,         o(0, 2, 2, 0, 0));
        vecs[7]  = mk(CLR | START, o(0, 0, 3, 0, 0));
        vecs[8]  = mk(START,       o(0, 0, 3, 1, 0));
        vecs[9]  = mk(HIT,         o(0, 1, 3, 1, 0));
        vecs[10] = mk(CLR | MISS,  o(0, 0, 3, 0, 0));
        vecs[11] = mk(MISS,        o(0, 0, 3, 0, 0));
        vecs[12] = mk(TICK | HIT,  o(0, 0, 3, 0, 0));

        reset = 1'b1;
        {btn_start, btn_clr, hit, miss, refr_tick} = IDLE;
        #12;
        compareNow(o(0, 0, 3, 0, 0), "reset_values");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[k]) applyStimulus(vecs[k].in, vecs[k].exp, $sformatf("table_%0d", k));

        // Score counting through the tens carry and the 99 -> 00 wrap
        applyStimulus(START, o(0, 0, 3, 1, 0), "start_play");
        for (int k = 1; k <= 100; k++)
            applyStimulus(HIT, o((k % 100) / 10, k % 10, 3, 1, 0), $sformatf("hit_%0d", k));

        // Reach score 0/5, then hit and miss together
        for (int k = 1; k <= 5; k++) applyStimulus(HIT, o(0, k, 3, 1, 0), "hit_to_5");
        applyStimulus(HIT | MISS, o(0, 5, 2, 0, 0), "hit_miss_same_cycle");

        // NEWBALL: start held while the timer runs is ignored
        for (int k = 1; k <= 120; k++)
            applyStimulus(TICK | START, o(0, 5, 2, 0, 0), $sformatf("newball_wait_%0d", k));
        for (int k = 0; k < 3; k++) applyStimulus(TICK, o(0, 5, 2, 0, 0), "newball_tick_at_zero");
        applyStimulus(START, o(0, 5, 2, 1, 0), "newball_to_play");

        // Lose the last two balls and sit through OVER with every input ignored
        applyStimulus(MISS, o(0, 5, 1, 0, 0), "miss_ball_1");
        for (int k = 0; k < 120; k++) applyStimulus(TICK, o(0, 5, 1, 0, 0), "newball2_wait");
        applyStimulus(START, o(0, 5, 1, 1, 0), "newball2_to_play");
        applyStimulus(MISS, o(0, 5, 0, 0, 1), "miss_to_over");
        for (int k = 1; k <= 120; k++)
            applyStimulus(TICK | START | HIT | MISS, o(0, 5, 0, 0, 1), $sformatf("over_wait_%0d", k));
        applyStimulus(IDLE, o(0, 0, 3, 0, 0), "over_to_newgame");
        applyStimulus(IDLE, o(0, 0, 3, 0, 0), "newgame_hold");

        // Async reset between edges while in NEWBALL
        applyStimulus(START, o(0, 0, 3, 1, 0), "restart_play");
        applyStimulus(HIT, o(0, 1, 3, 1, 0), "restart_hit");
        applyStimulus(MISS, o(0, 1, 2, 0, 0), "restart_miss");
        #2;
        reset = 1'b1;
        #1;
        compareNow(o(0, 0, 3, 0, 0), "async_reset_midcycle");
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        compareNow(o(0, 0, 3, 0, 0), "after_reset_release");
        applyStimulus(IDLE, o(0, 0, 3, 0, 0), "wait_newgame_1");
        applyStimulus(TICK, o(0, 0, 3, 0, 0), "wait_newgame_2");
        applyStimulus(START, o(0, 0, 3, 1, 0), "start_after_reset");

        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
